// File: rtl/soc_run_mon_pkg.sv
// Shared types for the end-of-run monitor: FSM state encoding, end-cause encoding
// and the saturating change-counter helper.
package soc_run_mon_pkg;

    typedef enum logic [2:0] {
        ST_RUN,
        ST_DUMP_RD,
        ST_DUMP_WAIT,
        ST_DUMP_OUT,
        ST_DONE
    } state_e;

    typedef enum logic [2:0] {
        CAUSE_NONE,
        CAUSE_PASS,
        CAUSE_FAIL,
        CAUSE_TIMEOUT,
        CAUSE_STALL
    } end_cause_e;

    localparam int unsigned CHG_W = 16;

    function automatic logic [CHG_W-1:0] sat_inc_chg(input logic [CHG_W-1:0] v);
        return (v == '1) ? v : v + 1'b1;
    endfunction

endpackage

// File: rtl/soc_run_mon_dump_seq.sv
// Dump sequencer: walks RAM addresses 0..DUMP_DEPTH-1, one read per word, and presents each
// word on a valid/ready port. Idle in ST_RUN until start_i, terminal in ST_DONE until reset.
module soc_run_mon_dump_seq
    import soc_run_mon_pkg::*;
#(
    parameter int unsigned ADDR_W     = 12,
    parameter int unsigned DATA_W     = 32,
    parameter int unsigned DUMP_DEPTH = 4096
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              start_i,
    output state_e            state_o,
    output logic              mem_rd_en_o,
    output logic [ADDR_W-1:0] mem_rd_addr_o,
    input  logic [DATA_W-1:0] mem_rd_data_i,
    output logic              dump_valid_o,
    output logic [ADDR_W-1:0] dump_addr_o,
    output logic [DATA_W-1:0] dump_data_o,
    input  logic              dump_ready_i,
    output logic              finished_o
);

    localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(DUMP_DEPTH - 1);

    state_e            state_q, state_d;
    logic [ADDR_W-1:0] idx_q, idx_d;
    logic [DATA_W-1:0] data_q, data_d;
    logic              fin_q, fin_d;

    always_comb begin
        state_d      = state_q;
        idx_d        = idx_q;
        data_d       = data_q;
        fin_d        = 1'b0;
        mem_rd_en_o  = 1'b0;
        dump_valid_o = 1'b0;
        unique case (state_q)
            ST_RUN: begin
                if (start_i) begin
                    state_d = ST_DUMP_RD;
                    idx_d   = '0;
                end
            end
            ST_DUMP_RD: begin
                mem_rd_en_o = 1'b1;
                state_d     = ST_DUMP_WAIT;
            end
            ST_DUMP_WAIT: begin
                data_d  = mem_rd_data_i;
                state_d = ST_DUMP_OUT;
            end
            ST_DUMP_OUT: begin
                dump_valid_o = 1'b1;
                if (dump_ready_i) begin
                    if (idx_q == LAST_IDX) begin
                        state_d = ST_DONE;
                        fin_d   = 1'b1;
                    end else begin
                        idx_d   = idx_q + 1'b1;
                        state_d = ST_DUMP_RD;
                    end
                end
            end
            ST_DONE: ;
            default: state_d = ST_RUN;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= ST_RUN;
            idx_q   <= '0;
            data_q  <= '0;
            fin_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            data_q  <= data_d;
            fin_q   <= fin_d;
        end
    end

    assign state_o       = state_q;
    assign mem_rd_addr_o = idx_q;
    assign dump_addr_o   = idx_q;
    assign dump_data_o   = data_q;
    assign finished_o    = fin_q;

endmodule

// File: rtl/soc_run_monitor.sv
// End-of-run monitor: pass/fail signature, timeout, per-channel change counts, then RAM dump.
// Stall detection is built only when SOC_RUN_MON_STALL_DETECT_EN is defined.
module soc_run_monitor
    import soc_run_mon_pkg::*;
#(
    parameter int unsigned       NUM_CH         = 2,
    parameter int unsigned       GPIO_W         = 32,
    parameter int unsigned       END_CH         = 0,
    parameter logic [GPIO_W-1:0] PASS_SIG       = 32'h600D0001,
    parameter logic [GPIO_W-1:0] FAIL_SIG       = 32'hBAD00001,
    parameter int unsigned       TIMEOUT_CYCLES = 250000,
    parameter int unsigned       STALL_CYCLES   = 65536,
    parameter int unsigned       CNT_W          = 32,
    parameter int unsigned       DUMP_DEPTH     = 4096,
    parameter int unsigned       ADDR_W         = 12,
    parameter int unsigned       DATA_W         = 32
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [NUM_CH*GPIO_W-1:0] gpio_i,
    output logic                     mem_rd_en,
    output logic [ADDR_W-1:0]        mem_rd_addr,
    input  logic [DATA_W-1:0]        mem_rd_data,
    output logic                     dump_valid,
    output logic [ADDR_W-1:0]        dump_addr,
    output logic [DATA_W-1:0]        dump_data,
    input  logic                     dump_ready,
    output logic                     done,
    output logic                     pass,
    output logic                     fail,
    output logic                     timeout,
    output logic                     stall,
    output logic [CNT_W-1:0]         cycle_cnt,
    output logic [NUM_CH*CHG_W-1:0]  chg_cnt
);

    state_e            state;
    logic              seq_finished;
    logic              in_run;
    logic              start;
    logic              any_chg;
    logic              stall_hit;
    end_cause_e        cause;
    logic [GPIO_W-1:0] gpio_ch [NUM_CH];

    logic [GPIO_W-1:0] prev_q    [NUM_CH];
    logic [GPIO_W-1:0] prev_d    [NUM_CH];
    logic [CHG_W-1:0]  chg_cnt_q [NUM_CH];
    logic [CHG_W-1:0]  chg_cnt_d [NUM_CH];
    logic [CNT_W-1:0]  cycle_cnt_q, cycle_cnt_d;
    logic              pass_q, pass_d;
    logic              fail_q, fail_d;
    logic              timeout_q, timeout_d;
    logic              stall_q, stall_d;
    logic              done_q, done_d;

    always_comb begin
        any_chg = 1'b0;
        for (int unsigned k = 0; k < NUM_CH; k++) begin
            gpio_ch[k] = gpio_i[k*GPIO_W +: GPIO_W];
            if (gpio_ch[k] != prev_q[k]) any_chg = 1'b1;
        end
    end

`ifdef SOC_RUN_MON_STALL_DETECT_EN
    localparam int unsigned IDLE_W = $clog2(STALL_CYCLES + 1);

    logic [IDLE_W-1:0] idle_q, idle_d;

    // The stall fires on the cycle whose idle count would reach STALL_CYCLES.
    assign stall_hit = !any_chg && (idle_q == IDLE_W'(STALL_CYCLES - 1));

    always_comb begin
        idle_d = idle_q;
        if (in_run && (cause == CAUSE_NONE)) idle_d = any_chg ? '0 : idle_q + 1'b1;
    end

    always_ff @(posedge clk) begin
        if (rst) idle_q <= '0;
        else     idle_q <= idle_d;
    end
`else
    assign stall_hit = 1'b0;
`endif

    assign in_run = (state == ST_RUN);

    always_comb begin
        cause = CAUSE_NONE;
        if (gpio_ch[END_CH] == PASS_SIG)                          cause = CAUSE_PASS;
        else if (gpio_ch[END_CH] == FAIL_SIG)                     cause = CAUSE_FAIL;
        else if (cycle_cnt_q == CNT_W'(TIMEOUT_CYCLES - 1))       cause = CAUSE_TIMEOUT;
        else if (stall_hit)                                       cause = CAUSE_STALL;
    end

    assign start = in_run && (cause != CAUSE_NONE);

    // The ending cycle only latches the cause; all counters hold their last RUN value.
    always_comb begin
        prev_d      = prev_q;
        chg_cnt_d   = chg_cnt_q;
        cycle_cnt_d = cycle_cnt_q;
        pass_d      = pass_q;
        fail_d      = fail_q;
        timeout_d   = timeout_q;
        stall_d     = stall_q;
        done_d      = done_q | seq_finished;
        if (in_run) begin
            prev_d = gpio_ch;
            unique case (cause)
                CAUSE_NONE: begin
                    cycle_cnt_d = (cycle_cnt_q == '1) ? cycle_cnt_q : cycle_cnt_q + 1'b1;
                    for (int unsigned k = 0; k < NUM_CH; k++) begin
                        if (gpio_ch[k] != prev_q[k]) chg_cnt_d[k] = sat_inc_chg(chg_cnt_q[k]);
                    end
                end
                CAUSE_PASS:    pass_d    = 1'b1;
                CAUSE_FAIL:    fail_d    = 1'b1;
                CAUSE_TIMEOUT: timeout_d = 1'b1;
                CAUSE_STALL:   stall_d   = 1'b1;
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int unsigned k = 0; k < NUM_CH; k++) begin
                prev_q[k]    <= '0;
                chg_cnt_q[k] <= '0;
            end
            cycle_cnt_q <= '0;
            pass_q      <= 1'b0;
            fail_q      <= 1'b0;
            timeout_q   <= 1'b0;
            stall_q     <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            prev_q      <= prev_d;
            chg_cnt_q   <= chg_cnt_d;
            cycle_cnt_q <= cycle_cnt_d;
            pass_q      <= pass_d;
            fail_q      <= fail_d;
            timeout_q   <= timeout_d;
            stall_q     <= stall_d;
            done_q      <= done_d;
        end
    end

    soc_run_mon_dump_seq #(
        .ADDR_W    (ADDR_W),
        .DATA_W    (DATA_W),
        .DUMP_DEPTH(DUMP_DEPTH)
    ) u_dump_seq (
        .clk_i        (clk),
        .rst_i        (rst),
        .start_i      (start),
        .state_o      (state),
        .mem_rd_en_o  (mem_rd_en),
        .mem_rd_addr_o(mem_rd_addr),
        .mem_rd_data_i(mem_rd_data),
        .dump_valid_o (dump_valid),
        .dump_addr_o  (dump_addr),
        .dump_data_o  (dump_data),
        .dump_ready_i (dump_ready),
        .finished_o   (seq_finished)
    );

    always_comb begin
        chg_cnt = '0;
        for (int unsigned k = 0; k < NUM_CH; k++) chg_cnt[k*CHG_W +: CHG_W] = chg_cnt_q[k];
    end

    assign cycle_cnt = cycle_cnt_q;
    assign pass      = pass_q;
    assign fail      = fail_q;
    assign timeout   = timeout_q;
    assign stall     = stall_q;
    assign done      = done_q;

endmodule
